// File: rtl/cp0_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_unit_pkg
// Description : Shared definitions for coprocessor 0: register numbers,
//               exception codes, register field positions and default
//               constants for the identification and handler addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_unit_pkg;

    // Coprocessor-0 register numbers reachable through mtc0/mfc0
    typedef enum logic [4:0] {
        CP0_REG_SR    = 5'd12,
        CP0_REG_CAUSE = 5'd13,
        CP0_REG_EPC   = 5'd14,
        CP0_REG_PRID  = 5'd15
    } cp0_reg_e;

    // Exception codes carried down the pipeline to M
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // SR field positions
    localparam int c_sr_im_lo      = 10;
    localparam int c_sr_im_hi      = 15;
    localparam int c_sr_exl        = 1;
    localparam int c_sr_ie         = 0;

    // Cause field positions
    localparam int c_cause_bd      = 31;
    localparam int c_cause_ip_lo   = 10;
    localparam int c_cause_ip_hi   = 15;
    localparam int c_cause_exc_lo  = 2;
    localparam int c_cause_exc_hi  = 6;

    // Default constants
    localparam logic [31:0] c_prid_default       = 32'h2023_1123;
    localparam logic [31:0] c_handler_pc_default = 32'h0000_4180;

    // EPC is always word aligned: clear the two low address bits
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : cp0_unit_if
// Description : Bus between the M stage of the pipeline (master) and
//               coprocessor 0 (slave): mtc0/mfc0 access, exception fields,
//               interrupt lines, eret, and the flush/redirect outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface cp0_unit_if;

    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] M_pc;
    logic        M_BD;
    logic [4:0]  M_ExcCode;
    logic [5:0]  HWInt;
    logic        eret;
    logic [31:0] cp0_rdata;
    logic [31:0] EPC_out;
    logic        Req;
    logic [31:0] handler_pc;

    // Pipeline side
    modport master (
        output en, cp0_addr, cp0_wdata, M_pc, M_BD, M_ExcCode, HWInt, eret,
        input  cp0_rdata, EPC_out, Req, handler_pc
    );

    // Coprocessor side
    modport slave (
        input  en, cp0_addr, cp0_wdata, M_pc, M_BD, M_ExcCode, HWInt, eret,
        output cp0_rdata, EPC_out, Req, handler_pc
    );

endinterface
`default_nettype wire

// File: rtl/cp0_unit_req.sv
`default_nettype none
// ============================================================================
// Module      : cp0_unit_req
// Description : Combinational interrupt/exception request equations.
//               Interrupts are enabled lines masked by IM and gated by IE;
//               any non-zero exception code requests; both are blocked
//               while EXL is set so nothing nests or queues.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_unit_req (
    input  wire logic [5:0] i_hw_int,
    input  wire logic [5:0] i_sr_im,
    input  wire logic       i_sr_ie,
    input  wire logic       i_sr_exl,
    input  wire logic [4:0] i_exc_code,
    output logic            o_int_req,
    output logic            o_req
);

    logic w_exc_req;

    assign o_int_req = (|(i_hw_int & i_sr_im)) & i_sr_ie & ~i_sr_exl;
    assign w_exc_req = (i_exc_code != 5'd0) & ~i_sr_exl;
    assign o_req     = o_int_req | w_exc_req;

endmodule
`default_nettype wire

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
// Module      : cp0_unit
// Description : Coprocessor 0 for the pipelined MIPS core. Holds SR, Cause,
//               EPC and PRId, raises Req to flush the pipeline and redirect
//               fetch to the handler, and services mtc0/mfc0/eret from M.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID       = c_prid_default,
    parameter logic [31:0] HANDLER_PC = c_handler_pc_default
) (
    input  wire logic   clk,
    input  wire logic   reset,
    cp0_unit_if.slave   bus
);

    // Architectural state (only the implemented fields are stored)
    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_req;
    logic [31:0] w_epc_src;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic        w_wr_sr;
    logic        w_wr_epc;

    cp0_unit_req u_req (
        .i_hw_int   (bus.HWInt),
        .i_sr_im    (r_sr_im),
        .i_sr_ie    (r_sr_ie),
        .i_sr_exl   (r_sr_exl),
        .i_exc_code (bus.M_ExcCode),
        .o_int_req  (w_int_req),
        .o_req      (w_req)
    );

    // A delay-slot instruction returns to its branch, one word earlier
    assign w_epc_src = word_align(bus.M_BD ? (bus.M_pc - 32'd4) : bus.M_pc);

    assign w_sr    = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
    assign w_cause = {r_cause_bd, 15'd0, r_cause_ip, 3'd0, r_cause_exc, 2'd0};

    assign w_wr_sr  = bus.en && (bus.cp0_addr == CP0_REG_SR);
    assign w_wr_epc = bus.en && (bus.cp0_addr == CP0_REG_EPC);

    // Register update: reset, then request capture, else mtc0/eret
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im     <= 6'd0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= 6'd0;
            r_cause_exc <= 5'd0;
            r_epc       <= 32'd0;
        end else begin
            r_cause_ip <= bus.HWInt;
            if (w_req) begin
                // The M instruction is flushed, so any mtc0/eret it carried is dropped
                r_sr_exl    <= 1'b1;
                r_cause_exc <= w_int_req ? EXC_INT : bus.M_ExcCode;
                r_cause_bd  <= bus.M_BD;
                r_epc       <= w_epc_src;
            end else begin
                if (w_wr_sr) begin
                    r_sr_im  <= bus.cp0_wdata[c_sr_im_hi:c_sr_im_lo];
                    r_sr_exl <= bus.cp0_wdata[c_sr_exl];
                    r_sr_ie  <= bus.cp0_wdata[c_sr_ie];
                end
                if (w_wr_epc) begin
                    r_epc <= word_align(bus.cp0_wdata);
                end
                // Placed after the SR write so the EXL clear wins if both occur
                if (bus.eret) begin
                    r_sr_exl <= 1'b0;
                end
            end
        end
    end

    // mfc0 read mux on pre-edge state
    always_comb begin
        bus.cp0_rdata = 32'd0;
        case (bus.cp0_addr)
            CP0_REG_SR:    bus.cp0_rdata = w_sr;
            CP0_REG_CAUSE: bus.cp0_rdata = w_cause;
            CP0_REG_EPC:   bus.cp0_rdata = r_epc;
            CP0_REG_PRID:  bus.cp0_rdata = PRID;
            default:       bus.cp0_rdata = 32'd0;
        endcase
    end

    assign bus.Req        = w_req;
    assign bus.EPC_out    = r_epc;
    assign bus.handler_pc = HANDLER_PC;

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_unit
// Description : Self-checking bench for cp0_unit: directed vector table,
//               a short hand sequence, and randomized traffic compared to a
//               register-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_unit;
    import cp0_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cp0_unit_if bus();

    cp0_unit #(
        .PRID       (32'h2023_1123),
        .HANDLER_PC (32'h0000_4180)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state, held as whole architectural registers
    logic [31:0] m_sr, m_cause, m_epc;

    typedef struct {
        logic        rst;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  code;
        logic [5:0]  hw;
        logic        eret;
        logic        exp_req;
        logic [4:0]  chk_addr;
        logic [31:0] exp_val;
        logic        exp_req_after;
    } vec_t;

    localparam int c_nvec = 22;
    vec_t tbl [c_nvec];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic [4:0] addr,
                         input logic [31:0] wdata, input logic [31:0] pc, input logic bd,
                         input logic [4:0] code, input logic [5:0] hw, input logic er);
        reset         = rst;
        bus.en        = en;
        bus.cp0_addr  = addr;
        bus.cp0_wdata = wdata;
        bus.M_pc      = pc;
        bus.M_BD      = bd;
        bus.M_ExcCode = code;
        bus.HWInt     = hw;
        bus.eret      = er;
    endtask

    function automatic logic model_int();
        return ((bus.HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic model_req();
        return model_int() || ((bus.M_ExcCode != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h2023_1123;
            default: return 32'd0;
        endcase
    endfunction

    // Apply one clock edge to the model using the inputs held across it
    task automatic model_edge();
        logic ir, rq;
        if (reset) begin
            m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
        end else begin
            ir = model_int();
            rq = model_req();
            if (rq) begin
                m_sr[1] = 1'b1;
                m_cause = {bus.M_BD, 15'd0, bus.HWInt, 3'd0, (ir ? 5'd0 : bus.M_ExcCode), 2'd0};
                m_epc   = (bus.M_BD ? bus.M_pc - 32'd4 : bus.M_pc) & 32'hFFFF_FFFC;
            end else begin
                m_cause[15:10] = bus.HWInt;
                if (bus.en && bus.cp0_addr == 5'd12) m_sr  = bus.cp0_wdata & 32'h0000_FC03;
                if (bus.en && bus.cp0_addr == 5'd14) m_epc = bus.cp0_wdata & 32'hFFFF_FFFC;
                if (bus.eret) m_sr[1] = 1'b0;
            end
        end
    endtask

    initial begin
        logic [4:0] ra;
        // rst en addr wdata pc bd code hw eret | req chk_addr exp_val req_after
        tbl[0]  = '{1'b0, 1'b1, 5'd12, 32'h0000_0401, 32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 5'd12, 32'h0000_0401, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_3010, 1'b0, 5'd0,  6'h01, 1'b0, 1'b1, 5'd13, 32'h0000_0400, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_3014, 1'b0, 5'd0,  6'h01, 1'b0, 1'b0, 5'd14, 32'h0000_3010, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_3018, 1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 5'd12, 32'h0000_0401, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_3020, 1'b1, 5'd12, 6'h00, 1'b0, 1'b1, 5'd13, 32'h8000_0030, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_3024, 1'b0, 5'd4,  6'h01, 1'b0, 1'b0, 5'd13, 32'h8000_0430, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_3028, 1'b0, 5'd4,  6'h01, 1'b0, 1'b0, 5'd14, 32'h0000_301C, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_302C, 1'b0, 5'd4,  6'h01, 1'b1, 1'b0, 5'd12, 32'h0000_0401, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 5'd14, 32'h0000_5000, 32'h0000_3030, 1'b0, 5'd10, 6'h00, 1'b0, 1'b1, 5'd14, 32'h0000_3030, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_3034, 1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 5'd12, 32'h0000_0401, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 5'd14, 32'h0000_3047, 32'h0000_3038, 1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 5'd14, 32'h0000_3044, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0000_303C, 1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 5'd13, 32'h0000_0028, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 5'd15, 32'h0,         32'h0000_3040, 1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 5'd15, 32'h2023_1123, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_3044, 1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 5'd7,  32'h0000_0000, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0000_3048, 1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 5'd12, 32'h0000_FC03, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 5'd0,  32'h0,         32'h0000_304C, 1'b0, 5'd0,  6'h3F, 1'b0, 1'b0, 5'd12, 32'h0000_0000, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_3050, 1'b0, 5'd0,  6'h3F, 1'b0, 1'b0, 5'd13, 32'h0000_FC00, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 5'd12, 32'h0000_0403, 32'h0000_3054, 1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 5'd12, 32'h0000_0401, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_0000, 1'b1, 5'd5,  6'h00, 1'b0, 1'b1, 5'd14, 32'hFFFF_FFFC, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_3058, 1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 5'd13, 32'h8000_0014, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_305C, 1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 5'd12, 32'h0000_0401, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_3100, 1'b0, 5'd12, 6'h01, 1'b0, 1'b1, 5'd13, 32'h0000_0400, 1'b0};

        // Reset state
        drive(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0);
        @(posedge clk); #1;
        bus.cp0_addr = 5'd12; #1; check("reset_sr", bus.cp0_rdata, 32'h0);
        bus.cp0_addr = 5'd13; #1; check("reset_cause", bus.cp0_rdata, 32'h0);
        bus.cp0_addr = 5'd14; #1; check("reset_epc", bus.cp0_rdata, 32'h0);
        check("reset_req", {31'd0, bus.Req}, 32'h0);
        check("reset_epc_out", bus.EPC_out, 32'h0);
        check("handler_pc", bus.handler_pc, 32'h0000_4180);

        // Directed vector table
        for (int i = 0; i < c_nvec; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].en, tbl[i].addr, tbl[i].wdata, tbl[i].pc,
                  tbl[i].bd, tbl[i].code, tbl[i].hw, tbl[i].eret);
            #1;
            check($sformatf("vec%0d_req", i), {31'd0, bus.Req}, {31'd0, tbl[i].exp_req});
            @(posedge clk); #1;
            bus.en = 1'b0; bus.eret = 1'b0; bus.cp0_addr = tbl[i].chk_addr;
            #1;
            check($sformatf("vec%0d_rdata", i), bus.cp0_rdata, tbl[i].exp_val);
            check($sformatf("vec%0d_req_after", i), {31'd0, bus.Req}, {31'd0, tbl[i].exp_req_after});
        end

        // Hand sequence: EPC_out follows an mtc0 to EPC on the next cycle
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd14, 32'h0000_1237, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0);
        #1; check("epc_out_before", bus.EPC_out, 32'h0000_3100);
        @(posedge clk); #1;
        check("epc_out_after", bus.EPC_out, 32'h0000_1234);

        // Randomized traffic against the model, starting from reset
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0);
        @(posedge clk); model_edge();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            case ($urandom_range(0, 5))
                0, 4:    ra = 5'd12;
                1:       ra = 5'd13;
                2:       ra = 5'd14;
                3:       ra = 5'd15;
                default: ra = 5'($urandom);
            endcase
            drive(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 2) == 0),
                  ra,
                  $urandom,
                  $urandom,
                  1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
                  ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
                  ($urandom_range(0, 5) == 0));
            #1;
            check("rand_req", {31'd0, bus.Req}, {31'd0, model_req()});
            check("rand_rdata", bus.cp0_rdata, model_read(bus.cp0_addr));
            check("rand_epc_out", bus.EPC_out, m_epc);
            @(posedge clk);
            model_edge();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 for the P7 pipelined MIPS core; the consumer of the M-stage exception fields (ExcCode, BD, PC) that the E/M pipeline register produces.
- Holds SR, Cause, EPC and PRId, and evaluates interrupt and exception conditions in M.
- Drives Req, which flushes every pipeline register and redirects fetch to the handler.
- Services mtc0, mfc0 and eret.

Parameters:
- PRID, 32'h2023_1123, constant value returned for register 15.
- HANDLER_PC, 32'h0000_4180, handler entry address driven on handler_pc.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  mtc0 write enable from M stage.
- cp0_addr  in  5  register number for mtc0/mfc0 (12/13/14/15).
- cp0_wdata  in  32  mtc0 write data (forwarded GPR value).
- M_pc  in  32  PC of the instruction in M.
- M_BD  in  1  M instruction sits in a branch delay slot.
- M_ExcCode  in  5  exception code carried to M; 0 means none.
- HWInt  in  6  external interrupt lines [7:2].
- eret  in  1  eret in M.
- cp0_rdata  out  32  mfc0 read data.
- EPC_out  out  32  current EPC value, for eret redirect.
- Req  out  1  exception/interrupt request, combinational.
- handler_pc  out  32  constant HANDLER_PC.

Behaviour:
- Single clock domain; all state updates on posedge clk. Reset is synchronous, active-high.

Register fields:
- SR: IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
- Cause: BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
- EPC: 32 bits, bits [1:0] always 0.
- PRId: constant PRID.

Reset:
- SR, Cause and EPC are 0; therefore Req=0.

Request logic (combinational):
- IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- ExcReq = (M_ExcCode != 0) & ~SR.EXL.
- Req = IntReq | ExcReq.
- Interrupt has priority over exception.

On a clock edge with Req=1:
- SR.EXL <= 1.
- Cause.ExcCode <= IntReq ? 0 : M_ExcCode.
- Cause.BD <= M_BD.
- EPC <= (M_BD ? M_pc-4 : M_pc) with bits [1:0] cleared; 32-bit wrap on M_pc-4.

Every clock edge (not reset):
- Cause.IP <= HWInt, regardless of Req, en or EXL.

mtc0 (edge with en=1 and Req=0), writable fields only:
- addr 12 writes SR IM/EXL/IE.
- addr 14 writes EPC with bits [1:0] cleared.
- addr 13 and 15 are ignored (Cause is read-only to software).

eret (edge with eret=1 and Req=0):
- SR.EXL <= 0.

Simultaneous events:
- Req wins over mtc0 and eret in the same cycle: the write/eret is dropped, because the instruction is flushed and re-executed after return.
- mtc0 to SR and eret in the same cycle cannot occur (one M instruction); if forced, eret's EXL clear takes precedence over the written EXL bit.

Read path:
- cp0_rdata is combinational from cp0_addr: 12→SR, 13→Cause, 14→EPC, 15→PRID, others→0.
- The read reflects pre-edge state; there is no internal write-to-read bypass.

Nesting:
- While EXL=1, both IntReq and ExcReq are masked; a pending M_ExcCode or HWInt is ignored, not queued.

EPC_out:
- Equals the EPC register; the eret redirect uses the post-update value on the cycle after any mtc0 to EPC.

Reset mid-operation:
- Reset overrides Req, mtc0 and eret in the same edge.

Decomposition:
- Shared package (cpu_defs):
  - CP0 register numbers SR=12, CAUSE=13, EPC=14, PRID=15.
  - ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
  - Field bit positions.
  - HANDLER_PC.
- No sub-module needed. Optional small combinational cp0_req_logic for the Req/IntReq equations, reusable by the bench as a reference model.

Test Plan:
- Reset, then mtc0 SR=32'h0000_0401 (IM[2]=1, IE=1), HWInt=6'b000001 → Req=1 combinationally; after the edge Cause=32'h0000_0400, ExcCode=0, EXL=1, EPC=M_pc (e.g. 32'h0000_3010), Req drops to 0.
- M_ExcCode=12 (Ov), M_pc=32'h0000_3020, M_BD=1, EXL=0 → Req=1; after the edge EPC=32'h0000_301C, Cause=32'h8000_0030, SR.EXL=1.
- EXL=1 with M_ExcCode=4 and HWInt active → Req stays 0; Cause.ExcCode is unchanged while IP tracks HWInt. Then eret → EXL=0 next cycle, Req rises if conditions still hold.
- Same cycle en=1 (addr 14, wdata=32'h0000_5000) and M_ExcCode=10 → EPC=M_pc, not 32'h0000_5000; SR.EXL=1.
- mtc0 addr 14 wdata=32'h0000_3047 → EPC_out=32'h0000_3044; mfc0 addr 15 → PRID; addr 7 → 0; mtc0 addr 13 leaves Cause unchanged.
- Assert reset while EXL=1 and HWInt active → SR, Cause and EPC are 0 after the edge, Req=0.
